decode_ctrl_pipe: RTL and testbench



---
 rtl/decode_ctrl_pipe.sv | 168 ++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: registered SimpleRISC control decode with a one-entry
// valid/ready output register, a multi-cycle execute stall counter and a
// branch flush.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 in the same cycle. The producer holds inst steady while in_valid is
// high and in_ready is low. This stage holds ctrl and is_illegal steady while
// out_valid is high and out_ready is low. flush overrides both transfers for
// the cycle in which it is asserted.
module decode_ctrl_pipe #(
  parameter int INST_W  = 32,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [21:0]       ctrl,
  output logic              is_illegal,
  output logic              busy
);

  // Bit positions inside the ctrl bundle.
  localparam int B_ST   = 0;
  localparam int B_LD   = 1;
  localparam int B_BEQ  = 2;
  localparam int B_BGT  = 3;
  localparam int B_RET  = 4;
  localparam int B_IMM  = 5;
  localparam int B_WB   = 6;
  localparam int B_UBR  = 7;
  localparam int B_CALL = 8;
  localparam int B_ADD  = 9;
  localparam int B_SUB  = 10;
  localparam int B_CMP  = 11;
  localparam int B_MUL  = 12;
  localparam int B_DIV  = 13;
  localparam int B_MOD  = 14;
  localparam int B_LSL  = 15;
  localparam int B_LSR  = 16;
  localparam int B_ASR  = 17;
  localparam int B_OR   = 18;
  localparam int B_AND  = 19;
  localparam int B_NOT  = 20;
  localparam int B_MOV  = 21;

  // The counter only has to hold LAT-1 of the longer operation.
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_RELOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_RELOAD = CNT_W'(DIV_LAT - 1);

  logic [4:0]       op;
  logic             imm;
  logic [21:0]      ctrl_d, ctrl_q;
  logic             illegal_d, illegal_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] busy_cnt_d, busy_cnt_q;
  logic             accept, consume;
  logic             unused_inst_bits;

  assign op  = inst[INST_W-1 -: 5];
  assign imm = inst[INST_W-6];
  // Operand fields are decoded downstream, not here.
  assign unused_inst_bits = ^inst[INST_W-7:0];

  assign in_ready = !flush && (busy_cnt_q == '0) && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = valid_q && out_ready && !flush;

  // Combinational decode of the incoming opcode into the control bundle.
  always_comb begin
    ctrl_d    = '0;
    illegal_d = 1'b0;
    case (op)
      5'd0:  ctrl_d[B_ADD]  = 1'b1;
      5'd1:  ctrl_d[B_SUB]  = 1'b1;
      5'd2:  ctrl_d[B_MUL]  = 1'b1;
      5'd3:  ctrl_d[B_DIV]  = 1'b1;
      5'd4:  ctrl_d[B_MOD]  = 1'b1;
      5'd5:  ctrl_d[B_CMP]  = 1'b1;
      5'd6:  ctrl_d[B_AND]  = 1'b1;
      5'd7:  ctrl_d[B_OR]   = 1'b1;
      5'd8:  ctrl_d[B_NOT]  = 1'b1;
      5'd9:  ctrl_d[B_MOV]  = 1'b1;
      5'd10: ctrl_d[B_LSL]  = 1'b1;
      5'd11: ctrl_d[B_LSR]  = 1'b1;
      5'd12: ctrl_d[B_ASR]  = 1'b1;
      5'd13: ctrl_d         = '0;
      5'd14: ctrl_d[B_LD]   = 1'b1;
      5'd15: ctrl_d[B_ST]   = 1'b1;
      5'd16: ctrl_d[B_BEQ]  = 1'b1;
      5'd17: ctrl_d[B_BGT]  = 1'b1;
      5'd18: ctrl_d[B_UBR]  = 1'b1;
      5'd19: begin
        ctrl_d[B_CALL] = 1'b1;
        ctrl_d[B_UBR]  = 1'b1;
      end
      5'd20: begin
        ctrl_d[B_RET] = 1'b1;
        ctrl_d[B_UBR] = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
    // Immediate form exists for ALU ops, ld and st only.
    if ((op <= 5'd12) || (op == 5'd14) || (op == 5'd15)) begin
      ctrl_d[B_IMM] = imm;
    end
    // Register writeback: ALU ops except cmp, plus ld and call (link).
    if (((op <= 5'd12) && (op != 5'd5)) || (op == 5'd14) || (op == 5'd19)) begin
      ctrl_d[B_WB] = 1'b1;
    end
  end

  // Next state of the output register and the execute stall counter.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end

    busy_cnt_d = busy_cnt_q;
    if (consume && ctrl_q[B_MUL]) begin
      busy_cnt_d = MUL_RELOAD;
    end else if (consume && (ctrl_q[B_DIV] || ctrl_q[B_MOD])) begin
      busy_cnt_d = DIV_RELOAD;
    end else if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - 1'b1;
    end
  end

  // Valid flag and stall counter; reset clears both immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      busy_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Payload register loads only on accept and otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid  = valid_q;
  assign ctrl       = ctrl_q;
  assign is_illegal = illegal_q;
  assign busy       = (busy_cnt_q != '0);

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: directed and random stimulus for decode_ctrl_pipe,
// checked cycle by cycle against an opcode-level reference model.
module tb_decode_ctrl_pipe;

  localparam int INST_W  = 32;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [21:0] ctrl;
  logic        is_illegal;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state: held opcode, bundle and remaining execute cycles.
  bit          m_valid;
  int          m_op;
  logic [21:0] m_ctrl;
  bit          m_illegal;
  int          m_busy;
  bit          m_acc;

  decode_ctrl_pipe #(
    .INST_W (INST_W),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst      (inst),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ctrl      (ctrl),
    .is_illegal(is_illegal),
    .busy      (busy)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control bundle straight from the opcode table.
  function automatic logic [21:0] ref_ctrl(input int op, input bit imm);
    int alu_bit[13] = '{9, 10, 12, 13, 14, 11, 19, 18, 20, 21, 15, 16, 17};
    logic [21:0] c = '0;
    if (op <= 12) c[alu_bit[op]] = 1'b1;
    if (op == 15) c[0] = 1'b1;
    if (op == 14) c[1] = 1'b1;
    if (op == 16) c[2] = 1'b1;
    if (op == 17) c[3] = 1'b1;
    if (op == 20) c[4] = 1'b1;
    if (imm && (op <= 12 || op == 14 || op == 15)) c[5] = 1'b1;
    if ((op <= 4) || (op >= 6 && op <= 12) || op == 14 || op == 19) c[6] = 1'b1;
    if (op == 18 || op == 19 || op == 20) c[7] = 1'b1;
    if (op == 19) c[8] = 1'b1;
    return c;
  endfunction

  function automatic logic [31:0] mk(input int op, input bit imm);
    logic [31:0] r;
    logic [4:0]  o;
    r = $urandom;
    o = op[4:0];
    r[31:27] = o;
    r[26] = imm;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_op = 13; m_ctrl = '0; m_illegal = 0; m_busy = 0; m_acc = 0;
  endtask

  // One clock cycle: drive at negedge, compare, then advance the model.
  task automatic cyc(input bit v, input logic [31:0] ins, input bit f, input bit r);
    bit exp_rdy, acc, cons;
    int op;
    @(negedge clk);
    in_valid = v; inst = ins; flush = f; out_ready = r;
    #1;
    exp_rdy = !f && (m_busy == 0) && (!m_valid || r);
    chk("in_ready",   {31'b0, in_ready},   {31'b0, exp_rdy});
    chk("out_valid",  {31'b0, out_valid},  {31'b0, m_valid});
    chk("ctrl",       {10'b0, ctrl},       {10'b0, m_ctrl});
    chk("is_illegal", {31'b0, is_illegal}, {31'b0, m_illegal});
    chk("busy",       {31'b0, busy},       {31'b0, (m_busy != 0)});
    acc  = v && exp_rdy;
    cons = m_valid && r && !f;
    if (cons && m_op == 2) m_busy = MUL_LAT - 1;
    else if (cons && (m_op == 3 || m_op == 4)) m_busy = DIV_LAT - 1;
    else if (m_busy > 0) m_busy--;
    if (f) m_valid = 0;
    else if (acc) m_valid = 1;
    else if (cons) m_valid = 0;
    if (acc) begin
      op = int'(ins[31:27]);
      m_op = op;
      m_ctrl = ref_ctrl(op, ins[26]);
      m_illegal = (op >= 21);
    end
    m_acc = acc;
  endtask

  // Offer one instruction until it is taken, with a cycle budget.
  task automatic send(input logic [31:0] ins, input bit r);
    bit done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      cyc(1'b1, ins, 1'b0, r);
      done = m_acc;
    end
    chk("send_accepted", {31'b0, done}, 32'd1);
  endtask

  task automatic idle(input int n, input bit r);
    for (int k = 0; k < n; k++) cyc(1'b0, mk(13, 0), 1'b0, r);
  endtask

  initial begin
    int guard;
    in_valid = 0; inst = '0; flush = 0; out_ready = 1; rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid",  {31'b0, out_valid},  32'd0);
    chk("rst_ctrl",       {10'b0, ctrl},       32'd0);
    chk("rst_is_illegal", {31'b0, is_illegal}, 32'd0);
    chk("rst_busy",       {31'b0, busy},       32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Stream add, sub, mul, beq, st, ret with the consumer always ready.
    send(mk(0, 0), 1);
    send(mk(1, 0), 1);
    send(mk(2, 0), 1);
    send(mk(16, 0), 1);
    send(mk(15, 0), 1);
    send(mk(20, 0), 1);
    idle(2, 1);

    // Immediate bit honoured for add, ignored for beq.
    send(mk(0, 1), 1);
    send(mk(16, 1), 1);
    idle(2, 1);

    // Hold a div with back-pressure, then release and watch the stall.
    send(mk(3, 1), 0);
    idle(4, 0);
    idle(10, 1);

    // nop and an illegal opcode.
    send(mk(13, 1), 1);
    send(mk(25, 0), 1);
    idle(2, 1);

    // Flush while holding an instruction and offering opcode 9.
    send(mk(7, 0), 0);
    cyc(1'b1, mk(9, 0), 1'b1, 1'b1);
    idle(2, 1);

    // Flush throughout a div stall: the counter still drains.
    send(mk(4, 0), 1);
    cyc(1'b0, mk(13, 0), 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) cyc(1'b1, mk(9, 0), 1'b1, 1'b1);
    idle(2, 1);

    // Reset in the middle of a div stall at count 5.
    send(mk(3, 0), 1);
    guard = 0;
    while (m_busy != 5 && guard < 20) begin
      cyc(1'b0, mk(13, 0), 1'b0, 1'b1);
      guard++;
    end
    chk("stall_reached_5", m_busy, 32'd5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",      {31'b0, busy},      32'd0);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1);

    // Random traffic, including illegal opcodes, flushes and back-pressure.
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 3) != 0), mk($urandom_range(0, 31), $urandom_range(0, 1)),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
    end
    idle(10, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
